// File: rtl/gpreg_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// gpreg_ctrl_pkg
// Shared definitions for the general-purpose register transfer controller:
//   - xfer_state_e : transfer FSM states (IDLE / DRIVE / LOAD)
//   - NUM_GPREGS   : number of general-purpose registers on the main bus
//   - SRC_*        : request source codes (gpreg 0..3, ALU result)
//   - src_is_gpreg / is_bad_req : request classification helpers
// -----------------------------------------------------------------------------
package gpreg_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_LOAD  = 2'd2
  } xfer_state_e;

  localparam int NUM_GPREGS = 4;

  localparam logic [2:0] SRC_GPREG0 = 3'd0;
  localparam logic [2:0] SRC_GPREG1 = 3'd1;
  localparam logic [2:0] SRC_GPREG2 = 3'd2;
  localparam logic [2:0] SRC_GPREG3 = 3'd3;
  localparam logic [2:0] SRC_ALU    = 3'd4;

  // True when the source code names one of the general-purpose registers.
  function automatic logic src_is_gpreg(input logic [2:0] src);
    logic hit;
    case (src)
      SRC_GPREG0, SRC_GPREG1, SRC_GPREG2, SRC_GPREG3: hit = 1'b1;
      default:                                        hit = 1'b0;
    endcase
    return hit;
  endfunction

  // A request is rejected when its source is reserved, or when a gpreg
  // would be copied onto itself (no useful work, and it would assert and
  // load the same register in the same cycle).
  function automatic logic is_bad_req(input logic [2:0] src,
                                      input logic [1:0] dst);
    logic bad;
    if (src_is_gpreg(src)) begin
      bad = (src[1:0] == dst);
    end else if (src == SRC_ALU) begin
      bad = 1'b0;
    end else begin
      bad = 1'b1;
    end
    return bad;
  endfunction

endpackage

// File: rtl/onehot_bar_dec.sv
// -----------------------------------------------------------------------------
// onehot_bar_dec
// Index-to-strobe decoder shared by every per-register strobe vector.
// Output is active low: with en=1 exactly bit [idx] is 0, otherwise all 1.
// Purely combinational; the caller registers the result.
// Ports:
//   idx : in  2           register index
//   en  : in  1           strobe enable
//   bar : out NUM_GPREGS  active-low one-hot strobe vector
// -----------------------------------------------------------------------------
module onehot_bar_dec
  import gpreg_ctrl_pkg::*;
(
  input  logic [1:0]            idx,
  input  logic                  en,
  output logic [NUM_GPREGS-1:0] bar
);

  // Clear the selected bit when enabled; all strobes idle high otherwise.
  always_comb begin
    bar = {NUM_GPREGS{1'b1}};
    if (en) begin
      bar[idx] = 1'b0;
    end else begin
      bar = {NUM_GPREGS{1'b1}};
    end
  end

endmodule

// File: rtl/gpreg_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// gpreg_xfer_ctrl
// Sequences one main-bus transfer at a time from a gpreg or the ALU result
// into a destination gpreg, and drives the ALU operand-bus strobes.
// A good transfer takes three cycles: DRIVE (source asserted), LOAD (source
// still asserted, destination load low), then back to IDLE with DONE.
// Rejected requests skip the strobes and pulse DONE+ERR the next cycle.
// Every output is a flop; next values are computed from the next state so
// the strobes line up with the state they belong to.
// Ports:
//   CLK, RST             : clock, synchronous active-high reset
//   REQ_valid/ready      : request handshake (ready == state is IDLE)
//   REQ_src[2:0]         : 0-3 gpreg, 4 ALU, 5-7 reserved (rejected)
//   REQ_dst[1:0]         : destination gpreg
//   OPERANDS_en, LHS_sel, RHS_sel : operand-bus control, FSM-independent
//   ASSERT_bar, LOAD_bar : per-gpreg main-bus assert / load, active low
//   ASSERT_LHS_bar, ASSERT_RHS_bar : per-gpreg operand-bus asserts
//   ALU_ASSERT_bar       : ALU result main-bus assert, active low
//   DONE, ERR            : one-cycle completion / rejection pulses
// -----------------------------------------------------------------------------
module gpreg_xfer_ctrl
  import gpreg_ctrl_pkg::*;
(
  input  logic                  CLK,
  input  logic                  RST,
  input  logic                  REQ_valid,
  output logic                  REQ_ready,
  input  logic [2:0]            REQ_src,
  input  logic [1:0]            REQ_dst,
  input  logic                  OPERANDS_en,
  input  logic [1:0]            LHS_sel,
  input  logic [1:0]            RHS_sel,
  output logic [NUM_GPREGS-1:0] ASSERT_bar,
  output logic [NUM_GPREGS-1:0] LOAD_bar,
  output logic [NUM_GPREGS-1:0] ASSERT_LHS_bar,
  output logic [NUM_GPREGS-1:0] ASSERT_RHS_bar,
  output logic                  ALU_ASSERT_bar,
  output logic                  DONE,
  output logic                  ERR
);

  xfer_state_e           state_r;
  xfer_state_e           next_state_s;
  logic [2:0]            src_r;
  logic [1:0]            dst_r;

  logic                  accept_s;
  logic                  bad_req_s;
  logic [2:0]            src_cap_s;

  logic                  main_en_s;
  logic                  alu_en_s;
  logic                  load_en_s;
  logic                  done_nxt_s;
  logic                  err_nxt_s;
  logic                  ready_nxt_s;

  logic [NUM_GPREGS-1:0] assert_nxt_s;
  logic [NUM_GPREGS-1:0] load_nxt_s;
  logic [NUM_GPREGS-1:0] lhs_nxt_s;
  logic [NUM_GPREGS-1:0] rhs_nxt_s;

  // Acceptance happens in IDLE only; anything presented elsewhere is ignored.
  assign accept_s  = (state_r == ST_IDLE) && REQ_valid;
  assign bad_req_s = accept_s && is_bad_req(REQ_src, REQ_dst);

  // On the accept edge the source is still on the inputs, not yet in src_r,
  // so the DRIVE strobe must be decoded from the live request.
  assign src_cap_s = accept_s ? REQ_src : src_r;

  // State register.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Request capture; holds source/destination for the rest of the transfer.
  always_ff @(posedge CLK) begin
    if (RST) begin
      src_r <= 3'd0;
      dst_r <= 2'd0;
    end else if (accept_s) begin
      src_r <= REQ_src;
      dst_r <= REQ_dst;
    end else begin
      src_r <= src_r;
      dst_r <= dst_r;
    end
  end

  // Next-state logic; rejected requests stay in IDLE.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (accept_s && !bad_req_s) begin
          next_state_s = ST_DRIVE;
        end else begin
          next_state_s = ST_IDLE;
        end
      end
      ST_DRIVE: next_state_s = ST_LOAD;
      ST_LOAD:  next_state_s = ST_IDLE;
      default:  next_state_s = ST_IDLE;
    endcase
  end

  // Next output values, derived from the state being entered.
  always_comb begin
    main_en_s   = 1'b0;
    alu_en_s    = 1'b0;
    load_en_s   = 1'b0;
    done_nxt_s  = 1'b0;
    err_nxt_s   = 1'b0;
    ready_nxt_s = (next_state_s == ST_IDLE);
    if (next_state_s != ST_IDLE) begin
      main_en_s = src_is_gpreg(src_cap_s);
      alu_en_s  = (src_cap_s == SRC_ALU);
      load_en_s = (next_state_s == ST_LOAD);
    end else begin
      main_en_s = 1'b0;
      alu_en_s  = 1'b0;
      load_en_s = 1'b0;
    end
    if (state_r == ST_LOAD) begin
      done_nxt_s = 1'b1;
    end else if (bad_req_s) begin
      done_nxt_s = 1'b1;
      err_nxt_s  = 1'b1;
    end else begin
      done_nxt_s = 1'b0;
      err_nxt_s  = 1'b0;
    end
  end

  onehot_bar_dec u_assert_dec (
    .idx (src_cap_s[1:0]),
    .en  (main_en_s),
    .bar (assert_nxt_s)
  );

  onehot_bar_dec u_load_dec (
    .idx (dst_r),
    .en  (load_en_s),
    .bar (load_nxt_s)
  );

  onehot_bar_dec u_lhs_dec (
    .idx (LHS_sel),
    .en  (OPERANDS_en),
    .bar (lhs_nxt_s)
  );

  onehot_bar_dec u_rhs_dec (
    .idx (RHS_sel),
    .en  (OPERANDS_en),
    .bar (rhs_nxt_s)
  );

  // Output registers; reset forces every strobe inactive and drops pulses.
  always_ff @(posedge CLK) begin
    if (RST) begin
      REQ_ready      <= 1'b1;
      ASSERT_bar     <= {NUM_GPREGS{1'b1}};
      LOAD_bar       <= {NUM_GPREGS{1'b1}};
      ASSERT_LHS_bar <= {NUM_GPREGS{1'b1}};
      ASSERT_RHS_bar <= {NUM_GPREGS{1'b1}};
      ALU_ASSERT_bar <= 1'b1;
      DONE           <= 1'b0;
      ERR            <= 1'b0;
    end else begin
      REQ_ready      <= ready_nxt_s;
      ASSERT_bar     <= assert_nxt_s;
      LOAD_bar       <= load_nxt_s;
      ASSERT_LHS_bar <= lhs_nxt_s;
      ASSERT_RHS_bar <= rhs_nxt_s;
      ALU_ASSERT_bar <= ~alu_en_s;
      DONE           <= done_nxt_s;
      ERR            <= err_nxt_s;
    end
  end

endmodule

// File: tb/tb_gpreg_xfer_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpreg_xfer_ctrl
// Directed bench for gpreg_xfer_ctrl. A transfer-level model (phase count
// since acceptance plus captured source/destination) predicts every output;
// a negedge process compares the DUT against it each cycle, and the directed
// sequences pin the model with hand-computed literal values.
// -----------------------------------------------------------------------------
module tb_gpreg_xfer_ctrl;

  logic       CLK;
  logic       RST;
  logic       REQ_valid;
  logic       REQ_ready;
  logic [2:0] REQ_src;
  logic [1:0] REQ_dst;
  logic       OPERANDS_en;
  logic [1:0] LHS_sel;
  logic [1:0] RHS_sel;
  logic [3:0] ASSERT_bar;
  logic [3:0] LOAD_bar;
  logic [3:0] ASSERT_LHS_bar;
  logic [3:0] ASSERT_RHS_bar;
  logic       ALU_ASSERT_bar;
  logic       DONE;
  logic       ERR;

  int pass_cnt  = 0;
  int total_cnt = 0;

  gpreg_xfer_ctrl dut (
    .CLK            (CLK),
    .RST            (RST),
    .REQ_valid      (REQ_valid),
    .REQ_ready      (REQ_ready),
    .REQ_src        (REQ_src),
    .REQ_dst        (REQ_dst),
    .OPERANDS_en    (OPERANDS_en),
    .LHS_sel        (LHS_sel),
    .RHS_sel        (RHS_sel),
    .ASSERT_bar     (ASSERT_bar),
    .LOAD_bar       (LOAD_bar),
    .ASSERT_LHS_bar (ASSERT_LHS_bar),
    .ASSERT_RHS_bar (ASSERT_RHS_bar),
    .ALU_ASSERT_bar (ALU_ASSERT_bar),
    .DONE           (DONE),
    .ERR            (ERR)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) begin
      pass_cnt++;
    end else begin
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(negedge CLK);
  endtask

  // ---------------- transfer-level model ----------------
  // m_phase: 0 idle, 1 first cycle after accept, 2 second cycle after accept.
  int         m_phase = 0;
  logic [2:0] m_src   = 3'd0;
  logic [1:0] m_dst   = 2'd0;
  logic       model_ok = 1'b0;
  logic       e_ready, e_alu, e_done, e_err;
  logic [3:0] e_assert, e_load, e_lhs, e_rhs;

  always @(posedge CLK) begin
    e_done = 1'b0;
    e_err  = 1'b0;
    if (RST) begin
      m_phase = 0;
    end else if (m_phase == 0) begin
      if (REQ_valid) begin
        if (REQ_src > 3'd4 || (REQ_src < 3'd4 && REQ_src[1:0] == REQ_dst)) begin
          e_done = 1'b1;
          e_err  = 1'b1;
        end else begin
          m_phase = 1;
          m_src   = REQ_src;
          m_dst   = REQ_dst;
        end
      end
    end else if (m_phase == 1) begin
      m_phase = 2;
    end else begin
      m_phase = 0;
      e_done  = 1'b1;
    end
    e_ready  = (m_phase == 0);
    e_assert = 4'hF;
    if (m_phase != 0 && m_src < 3'd4) e_assert[m_src[1:0]] = 1'b0;
    e_alu    = !(m_phase != 0 && m_src == 3'd4);
    e_load   = 4'hF;
    if (m_phase == 2) e_load[m_dst] = 1'b0;
    e_lhs    = (RST || !OPERANDS_en) ? 4'hF : ~(4'b0001 << LHS_sel);
    e_rhs    = (RST || !OPERANDS_en) ? 4'hF : ~(4'b0001 << RHS_sel);
    model_ok = 1'b1;
  end

  // Per-cycle comparison against the model, plus bus-exclusivity rules.
  always @(negedge CLK) begin
    if (model_ok) begin
      chk("m_ready",  {31'd0, REQ_ready},      {31'd0, e_ready});
      chk("m_assert", {28'd0, ASSERT_bar},     {28'd0, e_assert});
      chk("m_alu",    {31'd0, ALU_ASSERT_bar}, {31'd0, e_alu});
      chk("m_load",   {28'd0, LOAD_bar},       {28'd0, e_load});
      chk("m_lhs",    {28'd0, ASSERT_LHS_bar}, {28'd0, e_lhs});
      chk("m_rhs",    {28'd0, ASSERT_RHS_bar}, {28'd0, e_rhs});
      chk("m_done",   {31'd0, DONE},           {31'd0, e_done});
      chk("m_err",    {31'd0, ERR},            {31'd0, e_err});
      chk("one_driver", {31'd0, ($countones(~{ASSERT_bar, ALU_ASSERT_bar}) <= 1)}, 32'd1);
      chk("one_load",   {31'd0, ($countones(~LOAD_bar) <= 1)}, 32'd1);
    end
  end

  // Acceptance monitor for the back-to-back spacing check.
  int cyc = 0;
  int acc_cnt = 0;
  int acc_cyc[2];
  always @(posedge CLK) begin
    cyc <= cyc + 1;
    if (!RST && REQ_valid && REQ_ready) begin
      if (acc_cnt < 2) acc_cyc[acc_cnt] <= cyc;
      acc_cnt <= acc_cnt + 1;
    end
  end

  task automatic req(input logic [2:0] s, input logic [1:0] d);
    REQ_valid = 1'b1;
    REQ_src   = s;
    REQ_dst   = d;
  endtask

  initial begin
    RST = 1'b1; REQ_valid = 1'b0; REQ_src = 3'd0; REQ_dst = 2'd0;
    OPERANDS_en = 1'b0; LHS_sel = 2'd0; RHS_sel = 2'd0;
    tick(); tick();
    chk("rst_assert", {28'd0, ASSERT_bar}, 32'hF);
    chk("rst_load",   {28'd0, LOAD_bar},   32'hF);
    chk("rst_alu",    {31'd0, ALU_ASSERT_bar}, 32'd1);
    chk("rst_done",   {31'd0, DONE}, 32'd0);
    RST = 1'b0;
    tick();
    chk("ready_after_rst", {31'd0, REQ_ready}, 32'd1);

    // gpreg2 -> gpreg0
    req(3'd2, 2'd0);
    tick(); REQ_valid = 1'b0;
    chk("r2r_drive_assert", {28'd0, ASSERT_bar}, 32'hB);
    chk("r2r_drive_load",   {28'd0, LOAD_bar},   32'hF);
    chk("r2r_drive_ready",  {31'd0, REQ_ready},  32'd0);
    tick();
    chk("r2r_load_assert", {28'd0, ASSERT_bar}, 32'hB);
    chk("r2r_load_load",   {28'd0, LOAD_bar},   32'hE);
    tick();
    chk("r2r_done", {31'd0, DONE}, 32'd1);
    chk("r2r_err",  {31'd0, ERR},  32'd0);
    chk("r2r_idle_assert", {28'd0, ASSERT_bar}, 32'hF);
    chk("r2r_idle_load",   {28'd0, LOAD_bar},   32'hF);

    // ALU -> gpreg3
    req(3'd4, 2'd3);
    tick(); REQ_valid = 1'b0;
    chk("alu_c1_alu",    {31'd0, ALU_ASSERT_bar}, 32'd0);
    chk("alu_c1_assert", {28'd0, ASSERT_bar}, 32'hF);
    chk("alu_c1_load",   {28'd0, LOAD_bar},   32'hF);
    tick();
    chk("alu_c2_alu",    {31'd0, ALU_ASSERT_bar}, 32'd0);
    chk("alu_c2_load",   {28'd0, LOAD_bar},   32'h7);
    tick();
    chk("alu_done", {31'd0, DONE}, 32'd1);
    chk("alu_off",  {31'd0, ALU_ASSERT_bar}, 32'd1);

    // Self-copy is rejected
    req(3'd1, 2'd1);
    tick(); REQ_valid = 1'b0;
    chk("err_same_done",   {31'd0, DONE}, 32'd1);
    chk("err_same_err",    {31'd0, ERR},  32'd1);
    chk("err_same_assert", {28'd0, ASSERT_bar}, 32'hF);
    chk("err_same_ready",  {31'd0, REQ_ready},  32'd1);
    tick();
    chk("err_same_clear", {31'd0, DONE}, 32'd0);

    // Reserved source is rejected
    req(3'd6, 2'd0);
    tick(); REQ_valid = 1'b0;
    chk("err_rsv_done", {31'd0, DONE}, 32'd1);
    chk("err_rsv_err",  {31'd0, ERR},  32'd1);
    chk("err_rsv_alu",  {31'd0, ALU_ASSERT_bar}, 32'd1);
    tick();

    // Back-to-back: request held high across two transfers
    acc_cnt = 0;
    req(3'd0, 2'd1);
    tick();
    req(3'd1, 2'd2);
    tick(); tick(); tick();
    REQ_valid = 1'b0;
    chk("b2b_second_drive", {28'd0, ASSERT_bar}, 32'hD);
    tick(); tick(); tick();
    chk("b2b_count", acc_cnt, 32'd2);
    chk("b2b_gap", acc_cyc[1] - acc_cyc[0], 32'd3);

    // Operand buses during a gpreg3 -> gpreg1 transfer
    OPERANDS_en = 1'b1; LHS_sel = 2'd1; RHS_sel = 2'd1;
    req(3'd3, 2'd1);
    tick(); REQ_valid = 1'b0;
    chk("op_lhs", {28'd0, ASSERT_LHS_bar}, 32'hD);
    chk("op_rhs", {28'd0, ASSERT_RHS_bar}, 32'hD);
    chk("op_xfer_assert", {28'd0, ASSERT_bar}, 32'h7);
    OPERANDS_en = 1'b0;
    tick();
    chk("op_off_lhs", {28'd0, ASSERT_LHS_bar}, 32'hF);
    chk("op_off_rhs", {28'd0, ASSERT_RHS_bar}, 32'hF);
    chk("op_xfer_load", {28'd0, LOAD_bar}, 32'hD);
    OPERANDS_en = 1'b1; LHS_sel = 2'd2; RHS_sel = 2'd0;
    tick();
    chk("op_lhs2", {28'd0, ASSERT_LHS_bar}, 32'hB);
    chk("op_rhs2", {28'd0, ASSERT_RHS_bar}, 32'hE);
    OPERANDS_en = 1'b0;
    tick();

    // Reset in the LOAD cycle of a gpreg0 -> gpreg1 transfer
    req(3'd0, 2'd1);
    tick(); REQ_valid = 1'b0;
    tick();
    chk("abort_in_load", {28'd0, LOAD_bar}, 32'hD);
    RST = 1'b1;
    tick();
    chk("abort_assert", {28'd0, ASSERT_bar}, 32'hF);
    chk("abort_load",   {28'd0, LOAD_bar},   32'hF);
    chk("abort_done",   {31'd0, DONE}, 32'd0);
    tick();
    RST = 1'b0;
    tick();
    chk("abort_ready", {31'd0, REQ_ready}, 32'd1);
    chk("abort_nodone", {31'd0, DONE}, 32'd0);
    chk("abort_noload", {28'd0, LOAD_bar}, 32'hF);

    // Mixed traffic; the model tracks every cycle
    for (int i = 0; i < 300; i++) begin
      REQ_valid   = 1'($urandom_range(0, 1));
      REQ_src     = 3'($urandom_range(0, 7));
      REQ_dst     = 2'($urandom_range(0, 3));
      OPERANDS_en = 1'($urandom_range(0, 1));
      LHS_sel     = 2'($urandom_range(0, 3));
      RHS_sel     = 2'($urandom_range(0, 3));
      RST         = ($urandom_range(0, 40) == 0);
      tick();
    end
    RST = 1'b0; REQ_valid = 1'b0;
    tick(); tick(); tick();

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/gpreg_xfer_ctrl.md
GPREG_XFER_CTRL -- requirements
Module: gpreg_xfer_ctrl

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset, with clock port CLK and reset port RST.
REQ-002 Port list (name, direction, width, meaning):
- CLK  in  1  system clock; all state changes on the rising edge.
- RST  in  1  synchronous, active-high reset.
- REQ_valid  in  1  transfer request present.
- REQ_ready  out  1  controller can accept a request.
- REQ_src  in  3  source: 0-3 = gpreg n; 4 = ALU result; 5-7 reserved.
- REQ_dst  in  2  destination gpreg 0-3.
- OPERANDS_en  in  1  drive ALU operand buses.
- LHS_sel  in  2  gpreg driving the LHS operand bus.
- RHS_sel  in  2  gpreg driving the RHS operand bus.
- ASSERT_bar  out  4  per-gpreg main-bus assert, active low.
- LOAD_bar  out  4  per-gpreg load, active low.
- ASSERT_LHS_bar  out  4  per-gpreg LHS assert, active low.
- ASSERT_RHS_bar  out  4  per-gpreg RHS assert, active low.
- ALU_ASSERT_bar  out  1  ALU result main-bus assert, active low.
- DONE  out  1  one-cycle pulse: transfer finished.
- ERR  out  1  one-cycle pulse, coincident with DONE: request rejected.
REQ-003 All outputs SHALL be driven directly from registers (no combinational path from inputs to outputs).

Function
REQ-004 The FSM SHALL have states IDLE, DRIVE and LOAD.
REQ-005 REQ_ready SHALL be 1 exactly when the state is IDLE.
REQ-006 A request SHALL be accepted on an edge where REQ_valid=1 and REQ_ready=1, and REQ_src and REQ_dst SHALL be captured at that edge.
REQ-007 A valid request accepted at edge t0 SHALL sequence as follows:
- Edge t0 -> DRIVE: source assert low (ASSERT_bar[src], or ALU_ASSERT_bar when src=4).
- Edge t0+1 -> LOAD: source assert held low; LOAD_bar[dst] low.
- Edge t0+2 -> IDLE: all strobes high; DONE=1 for that one cycle.
REQ-008 The destination gpreg SHALL capture on edge t0+2; transfer latency is 3 cycles and the next request SHALL be acceptable at edge t0+3.
REQ-009 A request with REQ_src in 5-7, or with REQ_src<4 and REQ_src==REQ_dst, SHALL be accepted without any strobe activity, return to IDLE, and pulse DONE=1 and ERR=1 in the cycle after acceptance.
REQ-010 REQ_valid=1 outside IDLE SHALL be ignored; the requester SHALL hold the request until it is accepted.
REQ-011 At most one of ASSERT_bar[3:0] and ALU_ASSERT_bar SHALL be low in any cycle.
REQ-012 At most one bit of LOAD_bar SHALL be low in any cycle.
REQ-013 Operand buses SHALL be independent of the FSM and update one cycle after their inputs change:
- OPERANDS_en=1 at edge: ASSERT_LHS_bar[LHS_sel]=0 and ASSERT_RHS_bar[RHS_sel]=0, all other bits 1.
- OPERANDS_en=0 at edge: both vectors all 1.
REQ-014 LHS_sel==RHS_sel SHALL be permitted.
REQ-015 A gpreg being loaded MAY simultaneously drive an operand bus.

Reset
REQ-016 With RST=1 at an edge, the block SHALL enter IDLE and set:
- ASSERT_bar, LOAD_bar, ASSERT_LHS_bar and ASSERT_RHS_bar = 4'hF.
- ALU_ASSERT_bar = 1.
- DONE = 0, ERR = 0.
REQ-017 Reset SHALL take priority over acceptance and over any in-progress transfer; an aborted transfer SHALL produce no DONE pulse and no load.
REQ-018 REQ_ready SHALL be 1 in the first cycle after reset is released.

Structure
REQ-019 A shared package gpreg_ctrl_pkg SHALL hold:
- the FSM state enum;
- NUM_GPREGS=4;
- source codes SRC_GPREG0..3=0..3 and SRC_ALU=4.
REQ-020 A single sub-module onehot_bar_dec SHALL be used for every per-register strobe vector: a 2-bit index plus enable in, 4-bit active-low one-hot out.

Verification
REQ-021 Reset behaviour: RST high for 2 cycles mid-transfer (state LOAD, dst=1) -> all strobes 1 next cycle, DONE=0, LOAD_bar stays 4'hF, REQ_ready=1 after release.
REQ-022 Register-to-register transfer: src=2, dst=0 accepted at t0 -> ASSERT_bar=4'b1011 at t0+1..t0+2, LOAD_bar=4'b1110 at t0+2 only, DONE=1 at t0+3 with ERR=0.
REQ-023 ALU-to-register transfer: src=4, dst=3 -> ALU_ASSERT_bar=0 for 2 cycles, ASSERT_bar=4'hF throughout, LOAD_bar=4'b0111 in the second cycle.
REQ-024 Error requests:
- src=1, dst=1 -> DONE=ERR=1 one cycle after acceptance, no strobe ever low;
- src=6 -> same result.
REQ-025 Back-to-back requests: REQ_valid held high with src=0/dst=1, then src=1/dst=2 -> second acceptance exactly 3 cycles after the first, no overlapping bus drivers.
REQ-026 Operand buses: OPERANDS_en=1, LHS_sel=1, RHS_sel=1 during a src=3/dst=1 transfer -> ASSERT_LHS_bar=ASSERT_RHS_bar=4'b1101 one cycle later; OPERANDS_en=0 -> both 4'hF one cycle later.
